// File: rtl/m_axi_burst_writer.sv
// AXI3 write master: snapshots WORD_COUNT words on start and writes them as
// INCR bursts that never cross a 4 KB page, checking every write response.
module m_axi_burst_writer #(
  parameter int         DATA_WIDTH = 32,
  parameter int         ADDR_WIDTH = 64,
  parameter int         WORD_COUNT = 6,
  parameter int         MAX_BURST  = 16,
  parameter logic [3:0] AXI_ID     = 4'd0
) (
  input  logic                             clk,
  input  logic                             areset,
  input  logic                             start_i,
  input  logic [ADDR_WIDTH-1:0]            base_addr_i,
  input  logic [WORD_COUNT*DATA_WIDTH-1:0] words_i,
  output logic [2:0]                       status_o,
  output logic                             done_o,
  output logic [3:0]                       awid_o,
  output logic [ADDR_WIDTH-1:0]            awaddr_o,
  output logic [3:0]                       awlen_o,
  output logic [2:0]                       awsize_o,
  output logic [1:0]                       awburst_o,
  output logic                             awvalid_o,
  input  logic                             awready_i,
  output logic [3:0]                       wid_o,
  output logic [DATA_WIDTH-1:0]            wdata_o,
  output logic [DATA_WIDTH/8-1:0]          wstrb_o,
  output logic                             wlast_o,
  output logic                             wvalid_o,
  input  logic                             wready_i,
  input  logic [3:0]                       bid_i,
  input  logic [1:0]                       bresp_i,
  input  logic                             bvalid_i,
  output logic                             bready_o
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SIZE  = $clog2(BYTES);
  localparam int CNT_W = $clog2(WORD_COUNT + 1);
  localparam int IDX_W = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, DONE} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] buffer [WORD_COUNT];
  logic [ADDR_WIDTH-1:0] addr;
  logic [CNT_W-1:0]      remaining;
  logic [IDX_W-1:0]      word_idx;
  logic [4:0]            len;
  logic [4:0]            beat;

  logic [ADDR_WIDTH-1:0] start_addr, next_addr;
  logic [CNT_W-1:0]      next_rem;
  logic [4:0]            start_len, next_len;

  // Beats in the next burst: capped by MAX_BURST, words left, and room to the page end.
  function automatic logic [4:0] burst_len(input logic [11:0] offs, input logic [CNT_W-1:0] rem);
    logic [12:0] room;
    logic [12:0] l;
    room = (13'd4096 - {1'b0, offs}) >> SIZE;
    l    = 13'(MAX_BURST);
    if (13'(rem) < l) l = 13'(rem);
    if (room < l) l = room;
    return 5'(l);
  endfunction

  always_comb begin
    start_addr = base_addr_i & ~ADDR_WIDTH'(BYTES - 1);
    start_len  = burst_len(start_addr[11:0], CNT_W'(WORD_COUNT));
    next_addr  = addr + (ADDR_WIDTH'(len) << SIZE);
    next_rem   = remaining - CNT_W'(len);
    next_len   = burst_len(next_addr[11:0], next_rem);
  end

  assign awid_o    = AXI_ID;
  assign wid_o     = AXI_ID;
  assign awsize_o  = 3'(SIZE);
  assign awburst_o = 2'b01;
  assign wstrb_o   = {BYTES{wvalid_o}};
  assign wdata_o   = wvalid_o ? buffer[word_idx] : '0;

  always_ff @(posedge clk) begin
    if (state == IDLE && start_i) begin
      for (int k = 0; k < WORD_COUNT; k++) buffer[k] <= words_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      state     <= IDLE;
      status_o  <= '0;
      done_o    <= 1'b0;
      awaddr_o  <= '0;
      awlen_o   <= '0;
      awvalid_o <= 1'b0;
      wlast_o   <= 1'b0;
      wvalid_o  <= 1'b0;
      bready_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            addr      <= start_addr;
            remaining <= CNT_W'(WORD_COUNT);
            word_idx  <= '0;
            len       <= start_len;
            awaddr_o  <= start_addr;
            awlen_o   <= 4'(start_len - 5'd1);
            awvalid_o <= 1'b1;
            status_o  <= 3'b001;
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (awready_i) begin
            awvalid_o <= 1'b0;
            wvalid_o  <= 1'b1;
            wlast_o   <= (len == 5'd1);
            beat      <= '0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (wready_i) begin
            word_idx <= word_idx + 1'b1;
            if (wlast_o) begin
              wvalid_o <= 1'b0;
              wlast_o  <= 1'b0;
              bready_o <= 1'b1;
              state    <= RESP;
            end else begin
              beat    <= beat + 5'd1;
              wlast_o <= (beat + 5'd2 == len);
            end
          end
        end
        RESP: begin
          if (bvalid_i) begin
            bready_o <= 1'b0;
            // A bad response or foreign ID abandons the rest of the transfer.
            if (bresp_i != 2'b00 || bid_i != AXI_ID) begin
              status_o[2] <= 1'b1;
              done_o      <= 1'b1;
              state       <= DONE;
            end else if (next_rem == '0) begin
              remaining <= '0;
              done_o    <= 1'b1;
              state     <= DONE;
            end else begin
              addr      <= next_addr;
              remaining <= next_rem;
              len       <= next_len;
              awaddr_o  <= next_addr;
              awlen_o   <= 4'(next_len - 5'd1);
              awvalid_o <= 1'b1;
              state     <= ADDR;
            end
          end
        end
        DONE: begin
          status_o <= {status_o[2], 2'b10};
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m_axi_burst_writer.sv
// Scoreboard bench for m_axi_burst_writer: a MAX_BURST=4 instance with stalls and
// error responses, plus a MAX_BURST=16 instance for the single-burst case.
module tb_m_axi_burst_writer;
  localparam int DW = 32;
  localparam int AW = 64;
  localparam int WC = 6;

  typedef struct packed { logic [63:0] addr; logic [3:0] len; } aw_t;
  typedef struct packed { logic [31:0] data; logic last; } w_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           areset = 1'b1;
  logic           start_i = 1'b0;
  logic           start16 = 1'b0;
  logic [AW-1:0]  base_addr_i = '0;
  logic [WC*DW-1:0] words_i = '0;

  logic [2:0] status_o;   logic done_o;
  logic [3:0] awid_o;     logic [AW-1:0] awaddr_o; logic [3:0] awlen_o;
  logic [2:0] awsize_o;   logic [1:0] awburst_o;   logic awvalid_o;
  logic       awready_i = 1'b1;
  logic [3:0] wid_o;      logic [DW-1:0] wdata_o;  logic [DW/8-1:0] wstrb_o;
  logic       wlast_o, wvalid_o;
  logic       wready_i = 1'b1;
  logic [3:0] bid_i = '0; logic [1:0] bresp_i = '0; logic bvalid_i = 1'b0; logic bready_o;

  logic [2:0] status16;   logic done16;
  logic [3:0] awid16;     logic [AW-1:0] awaddr16; logic [3:0] awlen16;
  logic [2:0] awsize16;   logic [1:0] awburst16;   logic awvalid16;
  logic [3:0] wid16;      logic [DW-1:0] wdata16;  logic [DW/8-1:0] wstrb16;
  logic       wlast16, wvalid16, bready16;

  m_axi_burst_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WORD_COUNT(WC), .MAX_BURST(4), .AXI_ID(4'd0)) dut (
    .clk(clk), .areset(areset), .start_i(start_i), .base_addr_i(base_addr_i), .words_i(words_i),
    .status_o(status_o), .done_o(done_o),
    .awid_o(awid_o), .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awsize_o(awsize_o), .awburst_o(awburst_o),
    .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wid_o(wid_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bid_i(bid_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o));

  m_axi_burst_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WORD_COUNT(WC), .MAX_BURST(16), .AXI_ID(4'd0)) dut16 (
    .clk(clk), .areset(areset), .start_i(start16), .base_addr_i(base_addr_i), .words_i(words_i),
    .status_o(status16), .done_o(done16),
    .awid_o(awid16), .awaddr_o(awaddr16), .awlen_o(awlen16), .awsize_o(awsize16), .awburst_o(awburst16),
    .awvalid_o(awvalid16), .awready_i(1'b1),
    .wid_o(wid16), .wdata_o(wdata16), .wstrb_o(wstrb16), .wlast_o(wlast16), .wvalid_o(wvalid16), .wready_i(1'b1),
    .bid_i(4'd0), .bresp_i(2'b00), .bvalid_i(bready16), .bready_o(bready16));

  int checks = 0;
  int failures = 0;
  aw_t exp_aw[$], exp_aw16[$];
  w_t  exp_w[$], exp_w16[$];
  logic [2:0] exp_st[$], exp_st16[$];
  logic [5:0] resp_q[$];
  bit  stall = 1'b0;
  int  done_seen = 0, done16_seen = 0, w_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic note_fail(input string name, input logic [63:0] act);
    checks++;
    failures++;
    $display("FAIL %s actual=%0h required=nothing", name, act);
  endtask

  // Ready and B-channel driving, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    awready_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    wready_i  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  bit b_hs = 1'b0;
  always @(negedge clk) b_hs = bvalid_i && bready_o && !areset;

  always @(posedge clk) begin
    #1;
    if (areset || b_hs) begin
      bvalid_i = 1'b0;
    end else if (bready_o && !bvalid_i && (!stall || $urandom_range(0, 1) == 1)) begin
      bvalid_i = 1'b1;
      if (resp_q.size() > 0) {bid_i, bresp_i} = resp_q.pop_front();
      else {bid_i, bresp_i} = 6'h00;
    end
  end

  // Monitor for the MAX_BURST=4 instance.
  aw_t ma; w_t mw;
  bit  aw_hold = 0, w_hold = 0, st_pend = 0;
  logic [63:0] aw_addr_h; logic [3:0] aw_len_h; logic [31:0] w_data_h; logic w_last_h;
  always @(negedge clk) begin
    if (areset) begin
      aw_hold = 0; w_hold = 0; st_pend = 0;
    end else begin
      if (st_pend) begin
        st_pend = 0;
        check("done_one_cycle", done_o, 0);
        if (exp_st.size() == 0) note_fail("status_unexpected", status_o);
        else check("status_end", status_o, exp_st.pop_front());
        done_seen++;
      end else if (done_o) st_pend = 1;
      if (aw_hold) begin
        check("aw_hold_valid", awvalid_o, 1);
        check("aw_hold_addr", awaddr_o, aw_addr_h);
        check("aw_hold_len", awlen_o, aw_len_h);
      end
      if (w_hold) begin
        check("w_hold_valid", wvalid_o, 1);
        check("w_hold_data", wdata_o, w_data_h);
        check("w_hold_last", wlast_o, w_last_h);
      end
      if (awvalid_o && awready_i) begin
        if (exp_aw.size() == 0) note_fail("aw_unexpected", awaddr_o);
        else begin
          ma = exp_aw.pop_front();
          check("aw_addr", awaddr_o, ma.addr);
          check("aw_len", awlen_o, ma.len);
          check("aw_attr", {awid_o, awsize_o, awburst_o}, 9'b0000_010_01);
        end
      end
      if (wvalid_o && wready_i) begin
        w_seen++;
        if (exp_w.size() == 0) note_fail("w_unexpected", wdata_o);
        else begin
          mw = exp_w.pop_front();
          check("w_data", wdata_o, mw.data);
          check("w_last", wlast_o, mw.last);
          check("w_attr", {wid_o, wstrb_o}, 8'h0F);
        end
      end
      aw_hold = awvalid_o && !awready_i; aw_addr_h = awaddr_o; aw_len_h = awlen_o;
      w_hold = wvalid_o && !wready_i; w_data_h = wdata_o; w_last_h = wlast_o;
    end
  end

  // Monitor for the MAX_BURST=16 instance (ready always high).
  aw_t ma16; w_t mw16; bit st16_pend = 0;
  always @(negedge clk) begin
    if (!areset) begin
      if (st16_pend) begin
        st16_pend = 0;
        check("d16_done_one_cycle", done16, 0);
        if (exp_st16.size() == 0) note_fail("d16_status_unexpected", status16);
        else check("d16_status_end", status16, exp_st16.pop_front());
        done16_seen++;
      end else if (done16) st16_pend = 1;
      if (awvalid16) begin
        if (exp_aw16.size() == 0) note_fail("d16_aw_unexpected", awaddr16);
        else begin
          ma16 = exp_aw16.pop_front();
          check("d16_aw_addr", awaddr16, ma16.addr);
          check("d16_aw_len", awlen16, ma16.len);
          check("d16_aw_attr", {awid16, awsize16, awburst16}, 9'b0000_010_01);
        end
      end
      if (wvalid16) begin
        if (exp_w16.size() == 0) note_fail("d16_w_unexpected", wdata16);
        else begin
          mw16 = exp_w16.pop_front();
          check("d16_w_data", wdata16, mw16.data);
          check("d16_w_last", wlast16, mw16.last);
          check("d16_w_attr", {wid16, wstrb16}, 8'h0F);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_words(input logic [31:0] pat);
    for (int k = 0; k < WC; k++) words_i[k*DW +: DW] = pat + 32'(k);
  endtask

  task automatic push_aw(input logic [63:0] a, input logic [3:0] l);
    exp_aw.push_back(aw_t'{addr: a, len: l});
  endtask

  task automatic push_w(input logic [31:0] pat, input int first, input int last_idx, input bit last_flag);
    for (int i = first; i <= last_idx; i++) exp_w.push_back(w_t'{data: pat + 32'(i), last: last_flag && (i == last_idx)});
  endtask

  task automatic start_xfer(input logic [63:0] base);
    base_addr_i = base;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("aw_valid_after_start", awvalid_o, 1);
    check("status_after_start", status_o, 3'b001);
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_seen < target && n < 400) begin tick(); n++; end
    if (done_seen < target) note_fail("done_timeout", n);
    check("aw_queue_drained", exp_aw.size(), 0);
    check("w_queue_drained", exp_w.size(), 0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valids"}, {awvalid_o, wvalid_o, wlast_o, bready_o, done_o}, 0);
    check({tag, "_status"}, status_o, 0);
    check({tag, "_awaddr"}, awaddr_o, 0);
    check({tag, "_awlen"}, awlen_o, 0);
    check({tag, "_wdata_strb"}, {wdata_o, wstrb_o}, 0);
  endtask

  initial begin
    int ndone;
    int n;
    int tgt;
    ndone = 0;
    repeat (3) tick();
    check_idle("reset");
    areset = 1'b0;
    tick();

    // MAX_BURST=16: single burst of six words
    set_words(32'hA000_0000);
    exp_aw16.push_back(aw_t'{addr: 64'h1000, len: 4'd5});
    for (int i = 0; i < 6; i++) exp_w16.push_back(w_t'{data: 32'hA000_0000 + 32'(i), last: (i == 5)});
    exp_st16.push_back(3'b010);
    base_addr_i = 64'h1000;
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    n = 0;
    while (done16_seen < 1 && n < 200) begin tick(); n++; end
    if (done16_seen < 1) note_fail("d16_done_timeout", n);
    check("d16_aw_drained", exp_aw16.size(), 0);
    check("d16_w_drained", exp_w16.size(), 0);

    // MAX_BURST=4: split into 4 + 2
    set_words(32'hB000_0000);
    push_aw(64'h1000, 4'd3); push_w(32'hB000_0000, 0, 3, 1);
    push_aw(64'h1010, 4'd1); push_w(32'hB000_0000, 4, 5, 1);
    exp_st.push_back(3'b010);
    start_xfer(64'h1000);
    wait_done(++ndone);

    // Page boundary at 0x1000: 2 + 4
    set_words(32'hC000_0000);
    push_aw(64'h0FF8, 4'd1); push_w(32'hC000_0000, 0, 1, 1);
    push_aw(64'h1000, 4'd3); push_w(32'hC000_0000, 2, 5, 1);
    exp_st.push_back(3'b010);
    start_xfer(64'h0FF8);
    wait_done(++ndone);

    // Random stalls, unaligned base, words changed after start
    stall = 1'b1;
    set_words(32'hD000_0000);
    push_aw(64'h2000, 4'd3); push_w(32'hD000_0000, 0, 3, 1);
    push_aw(64'h2010, 4'd1); push_w(32'hD000_0000, 4, 5, 1);
    exp_st.push_back(3'b010);
    start_xfer(64'h2002);
    set_words(32'hEEEE_0000);
    wait_done(++ndone);
    stall = 1'b0;

    // SLVERR on first response: no second burst
    set_words(32'hF000_0000);
    resp_q.push_back({4'h0, 2'b10});
    push_aw(64'h3000, 4'd3); push_w(32'hF000_0000, 0, 3, 1);
    exp_st.push_back(3'b110);
    start_xfer(64'h3000);
    wait_done(++ndone);

    // Next start clears the error and completes
    push_aw(64'h3000, 4'd3); push_w(32'hF000_0000, 0, 3, 1);
    push_aw(64'h3010, 4'd1); push_w(32'hF000_0000, 4, 5, 1);
    exp_st.push_back(3'b010);
    start_xfer(64'h3000);
    wait_done(++ndone);

    // Foreign BID is an error too
    set_words(32'h1234_0000);
    resp_q.push_back({4'h5, 2'b00});
    push_aw(64'h4000, 4'd3); push_w(32'h1234_0000, 0, 3, 1);
    exp_st.push_back(3'b110);
    start_xfer(64'h4000);
    wait_done(++ndone);

    // Reset during the third beat
    set_words(32'hB000_0000);
    push_aw(64'h1000, 4'd3); push_w(32'hB000_0000, 0, 1, 0);
    tgt = w_seen + 2;
    start_xfer(64'h1000);
    n = 0;
    while (w_seen < tgt && n < 50) begin tick(); n++; end
    if (w_seen < tgt) note_fail("beat_wait_timeout", n);
    areset = 1'b1;
    tick();
    check_idle("midreset");
    areset = 1'b0;
    check("rst_aw_drained", exp_aw.size(), 0);
    check("rst_w_drained", exp_w.size(), 0);
    tick();

    // Repeat of the split transfer, with a start pulse while busy
    push_aw(64'h1000, 4'd3); push_w(32'hB000_0000, 0, 3, 1);
    push_aw(64'h1010, 4'd1); push_w(32'hB000_0000, 4, 5, 1);
    exp_st.push_back(3'b010);
    start_xfer(64'h1000);
    tick();
    base_addr_i = 64'h5000;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wait_done(++ndone);
    check("status_after_busy_start", status_o, 3'b010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
